// File: rtl/piso_serializer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : piso_serializer_if                                             |
// | Brief   : Word handshake and framed serial output bundle for the         |
// |           parallel-in serial-out stage.                                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             sout_last;

  // Word producer / serial consumer side
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  sout,
    input  sout_valid,
    input  sout_first,
    input  sout_last
  );

  // Serializer side
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output sout,
    output sout_valid,
    output sout_first,
    output sout_last
  );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : piso_serializer                                                |
// | Brief   : Accepts a WIDTH-bit word over valid/ready and shifts it out    |
// |           one bit per clock with first/last framing strobes and an       |
// |           optional idle gap between words.                               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int GAP       = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  piso_serializer_if.slave    bus
);

  localparam int c_CNT_W = $clog2(WIDTH);
  // A zero-length gap still needs a legal one-bit counter; it simply never counts.
  localparam int c_GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_BIT_LAST   = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_BIT_PENULT = c_CNT_W'(WIDTH - 2);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST   = c_GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic               c_NO_GAP     = (GAP == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [c_GAP_W-1:0] r_gap_cnt;
  logic               r_sout;
  logic               r_sout_valid;
  logic               r_sout_first;
  logic               r_sout_last;

  logic               w_last_bit;
  logic               w_gap_end;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_load_bit;
  logic [WIDTH-1:0]   w_load_rest;
  logic               w_next_bit;
  logic [WIDTH-1:0]   w_next_rest;

  assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == c_BIT_LAST);
  assign w_gap_end  = (r_state == ST_GAP) && (r_gap_cnt == c_GAP_LAST);
  // Ready in the last bit cycle only when no gap follows, so words chain without a bubble.
  assign w_in_ready = (r_state == ST_IDLE) | (w_last_bit & c_NO_GAP) | w_gap_end;
  assign w_accept   = bus.in_valid & w_in_ready;

  // The shift register always presents the next bit at the end it is taken from;
  // the first bit of a word goes straight to sout on the accepting edge.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_load_bit  = bus.in_data[WIDTH-1];
      assign w_load_rest = {bus.in_data[WIDTH-2:0], 1'b0};
      assign w_next_bit  = r_shift[WIDTH-1];
      assign w_next_rest = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_load_bit  = bus.in_data[0];
      assign w_load_rest = {1'b0, bus.in_data[WIDTH-1:1]};
      assign w_next_bit  = r_shift[0];
      assign w_next_rest = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // Framing FSM: loads on accept, shifts one bit per clock, then gaps or idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_sout_first <= 1'b0;
      r_sout_last  <= 1'b0;
    end else if (w_accept) begin
      // Accept is only possible at IDLE, a gap-free last bit, or the final gap cycle.
      r_state      <= ST_SHIFT;
      r_shift      <= w_load_rest;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_sout       <= w_load_bit;
      r_sout_valid <= 1'b1;
      r_sout_first <= 1'b1;
      r_sout_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_sout_first <= 1'b0;
          r_sout_last  <= 1'b0;
        end
        ST_SHIFT: begin
          if (!w_last_bit) begin
            r_shift      <= w_next_rest;
            r_sout       <= w_next_bit;
            r_bit_cnt    <= r_bit_cnt + 1'b1;
            r_sout_first <= 1'b0;
            r_sout_last  <= (r_bit_cnt == c_BIT_PENULT);
          end else begin
            r_state      <= c_NO_GAP ? ST_IDLE : ST_GAP;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_sout_first <= 1'b0;
            r_sout_last  <= 1'b0;
          end
        end
        ST_GAP: begin
          if (!w_gap_end) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end else begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_bit_cnt    <= '0;
          r_gap_cnt    <= '0;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_sout_first <= 1'b0;
          r_sout_last  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.sout_first = r_sout_first;
  assign bus.sout_last  = r_sout_last;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_piso_serializer                                             |
// | Brief   : Three serializer configurations driven with directed and       |
// |           random words, compared against an expected-stream model.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_piso_serializer;

  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // 10 ns clock
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus0 ();
  piso_serializer_if #(.WIDTH(W)) bus1 ();
  piso_serializer_if #(.WIDTH(W)) bus2 ();

  piso_serializer #(.WIDTH(W), .GAP(0), .MSB_FIRST(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  piso_serializer #(.WIDTH(W), .GAP(2), .MSB_FIRST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  piso_serializer #(.WIDTH(W), .GAP(1), .MSB_FIRST(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [W-1:0] drv_data  [3];
  logic         drv_valid [3];
  logic [4:0]   obs       [3];   // {in_ready, sout_valid, sout, sout_first, sout_last}

  assign bus0.in_data  = drv_data[0];
  assign bus0.in_valid = drv_valid[0];
  assign bus1.in_data  = drv_data[1];
  assign bus1.in_valid = drv_valid[1];
  assign bus2.in_data  = drv_data[2];
  assign bus2.in_valid = drv_valid[2];

  assign obs[0] = {bus0.in_ready, bus0.sout_valid, bus0.sout, bus0.sout_first, bus0.sout_last};
  assign obs[1] = {bus1.in_ready, bus1.sout_valid, bus1.sout, bus1.sout_first, bus1.sout_last};
  assign obs[2] = {bus2.in_ready, bus2.sout_valid, bus2.sout, bus2.sout_first, bus2.sout_last};

  // Downstream 4-stage shift register fed by the LSB-first instance
  logic [3:0] sr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[2:0], bus2.sout};
  end

  typedef struct packed {
    logic v;
    logic b;
    logic f;
    logic l;
  } ent_t;

  int           gap_of [3];
  bit           msb_of [3];
  ent_t         mq     [3][$];   // expected outputs for coming cycles
  ent_t         cur    [3];      // expected outputs this cycle
  logic [W-1:0] dirq   [3][$];   // directed words waiting to be offered
  logic         hist   [$];      // expected sout history of instance 2

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string tag, logic [31:0] obs_v, logic [31:0] exp_v);
    n_checks++;
    if (obs_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs_v, exp_v);
  endtask

  // Schedule a whole word plus its trailing gap as future cycles
  task automatic model_accept(int k, logic [W-1:0] word);
    ent_t e;
    for (int i = 0; i < W; i++) begin
      int idx;
      idx = msb_of[k] ? (W - 1 - i) : i;
      e.v = 1'b1;
      e.b = word[idx];
      e.f = (i == 0);
      e.l = (i == W - 1);
      mq[k].push_back(e);
    end
    for (int g = 0; g < gap_of[k]; g++) mq[k].push_back('0);
  endtask

  task automatic check_reset_state(string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s i%0d in_ready", tag, k), obs[k][4], 1);
      check($sformatf("%s i%0d outputs", tag, k), obs[k][3:0], 0);
    end
    check($sformatf("%s chain", tag), sr, 0);
  endtask

  // One cycle: compare current outputs, then choose inputs for the next edge
  task automatic step(bit rnd);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("i%0d in_ready", k), obs[k][4], (mq[k].size() == 0) ? 1 : 0);
      check($sformatf("i%0d sout_valid", k), obs[k][3], cur[k].v);
      check($sformatf("i%0d sout", k), obs[k][2], cur[k].b);
      check($sformatf("i%0d sout_first", k), obs[k][1], cur[k].f);
      check($sformatf("i%0d sout_last", k), obs[k][0], cur[k].l);
    end
    if (hist.size() >= 4) check("chain q", sr[3], hist[hist.size() - 4]);
    hist.push_back(cur[2].b);

    for (int k = 0; k < 3; k++) begin
      bit directed;
      directed = (dirq[k].size() > 0);
      if (directed) begin
        drv_valid[k] = 1'b1;
        drv_data[k]  = dirq[k][0];
      end else if (rnd) begin
        drv_valid[k] = ($urandom_range(0, 3) != 0);
        drv_data[k]  = W'($urandom);
      end else begin
        drv_valid[k] = 1'b0;
        drv_data[k]  = '0;
      end
      if (drv_valid[k] && mq[k].size() == 0) begin
        model_accept(k, drv_data[k]);
        if (directed) void'(dirq[k].pop_front());
      end
      cur[k] = (mq[k].size() > 0) ? mq[k].pop_front() : ent_t'('0);
    end
  endtask

  // Reset asserted between clock edges; effect must be immediate
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_state("async");
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      dirq[k].delete();
      cur[k]       = '0;
      drv_valid[k] = 1'b0;
      drv_data[k]  = '0;
    end
    hist.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed framing scenarios followed by random traffic with resets
  initial begin
    gap_of = '{0, 2, 1};
    msb_of = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      drv_valid[k] = 1'b0;
      drv_data[k]  = '0;
      cur[k]       = '0;
    end
    #1 check_reset_state("power-on");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two words back-to-back with valid held
    for (int k = 0; k < 3; k++) begin
      dirq[k].push_back(4'b1011);
      dirq[k].push_back(4'b0110);
    end
    repeat (20) begin @(negedge clk); step(1'b0); end

    // Abort a word after two bits, then send a fresh one
    for (int k = 0; k < 3; k++) dirq[k].push_back(4'b1011);
    repeat (3) begin @(negedge clk); step(1'b0); end
    async_reset();
    for (int k = 0; k < 3; k++) dirq[k].push_back(4'b0101);
    repeat (12) begin @(negedge clk); step(1'b0); end

    // Random traffic, interrupted by resets at arbitrary points
    for (int r = 0; r < 4; r++) begin
      repeat (300 + $urandom_range(0, 100)) begin @(negedge clk); step(1'b1); end
      async_reset();
    end
    repeat (20) begin @(negedge clk); step(1'b1); end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
